// File: rtl/hsid_x_obi_arbiter.sv
// hsid_x_obi_arbiter: round-robin arbiter sharing one OBI read master port between N_PORTS requesters.
// Ports: clk, rst (sync, active-high); s_req/s_addr/s_gnt per requester; s_rvalid/s_rdata routed responses;
// m_obi_req/m_obi_rsp master port; err_unexp_rvalid sticky flag for a response with no outstanding access.
// Define HSID_X_OBI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
package hsid_x_obi_inf_pkg;
  localparam int HSID_WORD_WIDTH = 32;
  typedef struct packed {
    logic                       req;
    logic                       we;
    logic [3:0]                 be;
    logic [HSID_WORD_WIDTH-1:0] addr;
    logic [HSID_WORD_WIDTH-1:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic                       gnt;
    logic                       rvalid;
    logic [HSID_WORD_WIDTH-1:0] rdata;
  } obi_resp_t;
endpackage

module hsid_x_obi_arbiter
  import hsid_x_obi_inf_pkg::*;
#(
  parameter int N_PORTS         = 4,
  parameter int WORD_WIDTH      = HSID_WORD_WIDTH,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS-1:0]            s_req,
  input  logic [N_PORTS*WORD_WIDTH-1:0] s_addr,
  output logic [N_PORTS-1:0]            s_gnt,
  output logic [N_PORTS-1:0]            s_rvalid,
  output logic [WORD_WIDTH-1:0]         s_rdata,
  output obi_req_t                      m_obi_req,
  input  obi_resp_t                     m_obi_rsp,
  output logic                          err_unexp_rvalid
);
  localparam int IW = $clog2(N_PORTS);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [IW-1:0] sel, sel_n, pick, cur;
  logic [IW-1:0] fifo [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic pop, push, full, issue;
`ifndef HSID_X_OBI_ARB_FIXED_PRIO_EN
  logic [IW-1:0] rr_ptr;
`endif

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  // Scanning downwards lets the last hit (closest to the search start) win.
  always_comb begin
    pick = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
`ifdef HSID_X_OBI_ARB_FIXED_PRIO_EN
      if (s_req[k]) pick = IW'(k);
`else
      if (s_req[(int'(rr_ptr) + k) % N_PORTS]) pick = IW'((int'(rr_ptr) + k) % N_PORTS);
`endif
    end
  end

  // A pop in the same cycle frees a slot, so "full" only blocks when nothing drains.
  always_comb begin
    pop            = !rst && m_obi_rsp.rvalid && count != '0;
    full           = count == CW'(MAX_OUTSTANDING) && !pop;
    issue          = !rst && (state == LOCKED || (|s_req && !full));
    cur            = state == LOCKED ? sel : pick;
    push           = issue && m_obi_rsp.gnt;
    state_n        = issue && !push ? LOCKED : IDLE;
    sel_n          = cur;
    m_obi_req      = '0;
    m_obi_req.req  = issue;
    m_obi_req.addr = issue ? s_addr[cur*WORD_WIDTH +: WORD_WIDTH] : '0;
    s_gnt          = push ? N_PORTS'(1) << cur : '0;
    s_rvalid       = pop ? N_PORTS'(1) << fifo[rd_ptr] : '0;
    s_rdata        = pop ? m_obi_rsp.rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      sel              <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      err_unexp_rvalid <= 1'b0;
`ifndef HSID_X_OBI_ARB_FIXED_PRIO_EN
      rr_ptr           <= '0;
`endif
    end else begin
      state <= state_n;
      sel   <= sel_n;
      count <= count + CW'(push) - CW'(pop);
      if (push) begin
        fifo[wr_ptr] <= cur;
        wr_ptr       <= nxt(wr_ptr);
`ifndef HSID_X_OBI_ARB_FIXED_PRIO_EN
        rr_ptr       <= cur == IW'(N_PORTS - 1) ? '0 : cur + 1'b1;
`endif
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (m_obi_rsp.rvalid && count == '0) err_unexp_rvalid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hsid_x_obi_arbiter.sv
// tb_hsid_x_obi_arbiter: directed and randomized checks of the arbiter against a queue-based reference model.
module tb_hsid_x_obi_arbiter;
  import hsid_x_obi_inf_pkg::*;
  localparam int N = 4;
  localparam int W = HSID_WORD_WIDTH;
  localparam int M = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] s_req = '0;
  logic [N*W-1:0] s_addr = '0;
  logic [N-1:0] s_gnt, s_rvalid;
  logic [W-1:0] s_rdata;
  obi_req_t m_obi_req;
  obi_resp_t m_obi_rsp = '0;
  logic err_unexp_rvalid;
  int total = 0;
  int bad = 0;
  int q[$];
  int rr = 0;
  bit locked = 1'b0;
  int lsel = 0;
  bit err = 1'b0;
  logic [N-1:0] dut_gnt, dut_rv;
  logic dut_req, dut_err;
  logic [W-1:0] dut_addr;

  always #5 clk = ~clk;

  hsid_x_obi_arbiter #(.N_PORTS(N), .WORD_WIDTH(W), .MAX_OUTSTANDING(M)) dut (
    .clk(clk), .rst(rst), .s_req(s_req), .s_addr(s_addr), .s_gnt(s_gnt), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata), .m_obi_req(m_obi_req), .m_obi_rsp(m_obi_rsp), .err_unexp_rvalid(err_unexp_rvalid)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One checked clock cycle: inputs are already applied; outputs compared mid-cycle, then the model advances.
  task automatic cyc();
    int cand;
    bit req, pop;
    logic [N-1:0] eg, ev;
    @(negedge clk);
    cand = 0;
    req = 1'b0;
    pop = !rst && m_obi_rsp.rvalid && q.size() > 0;
    if (!rst) begin
      if (locked) begin
        cand = lsel;
        req = 1'b1;
      end else if (s_req != '0 && !(q.size() == M && !pop)) begin
        for (int k = N - 1; k >= 0; k--) if (s_req[(rr + k) % N]) cand = (rr + k) % N;
        req = 1'b1;
      end
    end
    eg = (req && m_obi_rsp.gnt) ? N'(1) << cand : '0;
    ev = pop ? N'(1) << q[0] : '0;
    dut_gnt = s_gnt;
    dut_rv = s_rvalid;
    dut_req = m_obi_req.req;
    dut_addr = m_obi_req.addr;
    dut_err = err_unexp_rvalid;
    check("m_req", W'(m_obi_req.req), W'(req));
    check("m_addr", m_obi_req.addr, req ? s_addr[cand*W +: W] : '0);
    check("m_other", W'({m_obi_req.we, m_obi_req.be}) | m_obi_req.wdata, '0);
    check("s_gnt", W'(s_gnt), W'(eg));
    check("s_rvalid", W'(s_rvalid), W'(ev));
    check("s_rdata", s_rdata, pop ? m_obi_rsp.rdata : '0);
    check("err", W'(err_unexp_rvalid), W'(err));
    if (rst) begin
      q.delete();
      rr = 0;
      locked = 1'b0;
      err = 1'b0;
    end else begin
      if (m_obi_rsp.rvalid && q.size() == 0) err = 1'b1;
      if (pop) void'(q.pop_front());
      if (eg != '0) begin
        q.push_back(cand);
`ifndef HSID_X_OBI_ARB_FIXED_PRIO_EN
        rr = (cand + 1) % N;
`endif
        locked = 1'b0;
      end else if (req) begin
        locked = 1'b1;
        lsel = cand;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_req = '0;
    m_obi_rsp = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drive(input int i, input logic [W-1:0] a);
    s_req[i] = 1'b1;
    s_addr[i*W +: W] = a;
  endtask

  initial begin
    cyc();
    check("rst_req", W'(dut_req), '0);
    rst = 1'b0;
    // single port
    m_obi_rsp.gnt = 1'b1;
    drive(2, 32'h0001_0005);
    cyc();
    check("sp_gnt", W'(dut_gnt), W'(4'b0100));
    check("sp_addr", dut_addr, 32'h0001_0005);
    s_req = '0;
    m_obi_rsp.rvalid = 1'b1;
    m_obi_rsp.rdata = 32'hCAFE_0123;
    cyc();
    check("sp_rv", W'(dut_rv), W'(4'b0100));
    // fairness
    do_reset();
    m_obi_rsp.gnt = 1'b1;
    for (int i = 0; i < N; i++) drive(i, W'(32'h100 + i));
    for (int t = 0; t < 6; t++) begin
      m_obi_rsp.rvalid = t > 0;
      m_obi_rsp.rdata = $urandom;
      cyc();
`ifdef HSID_X_OBI_ARB_FIXED_PRIO_EN
      check("fair", W'(dut_gnt), W'(4'b0001));
`else
      check("fair", W'(dut_gnt), W'(N'(1) << (t % N)));
`endif
    end
    s_req = '0;
    cyc();
    // lock
    do_reset();
    drive(1, 32'h0000_1111);
    cyc();
    check("lk_sel", dut_addr, 32'h0000_1111);
    drive(0, 32'h0000_2222);
    for (int t = 0; t < 3; t++) begin
      cyc();
      check("lk_hold", dut_addr, 32'h0000_1111);
      check("lk_nogrant", W'(dut_gnt), '0);
    end
    m_obi_rsp.gnt = 1'b1;
    cyc();
    check("lk_g1", W'(dut_gnt), W'(4'b0010));
    s_req[1] = 1'b0;
    cyc();
    check("lk_g0", W'(dut_gnt), W'(4'b0001));
    s_req = '0;
    m_obi_rsp.rvalid = 1'b1;
    repeat (2) cyc();
    // full
    do_reset();
    m_obi_rsp.gnt = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, W'(32'h200 + i));
    repeat (2) begin
      cyc();
      s_req &= ~dut_gnt;
    end
    repeat (2) begin
      cyc();
      check("full_req", W'(dut_req), '0);
    end
    m_obi_rsp.rvalid = 1'b1;
    m_obi_rsp.rdata = 32'h5A5A_0001;
    cyc();
    check("full_issue", W'(dut_req), W'(1'b1));
    check("full_gnt", W'(dut_gnt), W'(4'b0100));
    check("full_rv", W'(dut_rv), W'(4'b0001));
    s_req = '0;
    repeat (2) cyc();
    // interleaved responses
    do_reset();
    m_obi_rsp.gnt = 1'b1;
    drive(3, 32'h0000_3333);
    cyc();
    s_req = '0;
    drive(0, 32'h0000_0000);
    cyc();
    s_req = '0;
    m_obi_rsp.rvalid = 1'b1;
    cyc();
    check("il_rv3", W'(dut_rv), W'(4'b1000));
    cyc();
    check("il_rv0", W'(dut_rv), W'(4'b0001));
    // unexpected rvalid, then reset
    cyc();
    check("ux_rv", W'(dut_rv), '0);
    m_obi_rsp.rvalid = 1'b0;
    cyc();
    check("ux_err", W'(dut_err), W'(1'b1));
    do_reset();
    cyc();
    check("rst_err", W'(dut_err), '0);
    check("rst_gnt", W'(dut_gnt), '0);
    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      rst = $urandom_range(299) == 0;
      m_obi_rsp.gnt = 1'($urandom_range(1));
      m_obi_rsp.rvalid = q.size() > 0 ? 1'($urandom_range(1)) : $urandom_range(99) == 0;
      m_obi_rsp.rdata = $urandom;
      for (int i = 0; i < N; i++) if (!s_req[i] && $urandom_range(1) == 1) drive(i, $urandom);
      cyc();
      for (int i = 0; i < N; i++)
        if (dut_gnt[i]) begin
          if ($urandom_range(1) == 1) s_req[i] = 1'b0;
          else s_addr[i*W +: W] = $urandom;
        end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
